// File: rtl/pc_sequencer.sv
// Next-PC selection and fetch sequencing FSM with stall watchdog.
// Optional HALT state and Halt port are enabled by defining PC_SEQ_HALT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          STALL_MAX    = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
`ifdef PC_SEQ_HALT_EN
  input  logic        Halt,
`endif
  output logic [31:0] Address,
  output logic        IF_Flush,
  output logic        MisalignErr,
  output logic        StallTimeout,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t      state, state_next;
  logic [3:0]  stall_cnt, stall_cnt_next, stall_cnt_inc;
  logic        timeout_q, timeout_set;
  logic        halt_req;
  logic [31:0] redirect_raw;

`ifdef PC_SEQ_HALT_EN
  assign halt_req = Halt;
`else
  assign halt_req = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    Address      = PCResult;
    IF_Flush     = 1'b0;
    MisalignErr  = 1'b0;
    redirect_raw = '0;
    case (state)
      ST_INIT: begin
        Address    = RESET_VECTOR;
        IF_Flush   = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req)   state_next = ST_HALT;
        else if (Stall) state_next = ST_STALL;
        // Stall wins over any redirect; the redirect must be re-presented later.
        if (Stall) begin
          Address = PCResult;
        end else if (Jump || BranchTaken) begin
          redirect_raw = Jump ? JumpTarget : BranchTarget;
          Address      = {redirect_raw[31:2], 2'b00};
          IF_Flush     = 1'b1;
          MisalignErr  = |redirect_raw[1:0];
        end else begin
          Address = PCResult + 32'd4;
        end
      end
      ST_STALL: begin
        if (halt_req)    state_next = ST_HALT;
        else if (!Stall) state_next = ST_RUN;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: state_next = ST_INIT;
    endcase
    if (Reset) begin
      Address     = RESET_VECTOR;
      IF_Flush    = 1'b1;
      MisalignErr = 1'b0;
      state_next  = ST_INIT;
    end
  end

  assign stall_cnt_inc = (stall_cnt == 4'hF) ? 4'hF : stall_cnt + 4'd1;

  always_comb begin
    stall_cnt_next = stall_cnt;
    timeout_set    = 1'b0;
    if (state == ST_INIT) begin
      stall_cnt_next = 4'd0;
    end else if (state == ST_STALL) begin
      if (state_next == ST_RUN) begin
        stall_cnt_next = 4'd0;
      end else if (state_next == ST_STALL) begin
        stall_cnt_next = stall_cnt_inc;
        timeout_set    = (int'(stall_cnt_inc) == STALL_MAX);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_INIT;
      stall_cnt <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      timeout_q <= timeout_q | timeout_set;
    end
  end

  assign StallTimeout = timeout_q;
  assign State        = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the bench holds the ProgramCounter register.
// Halt steps are included only when PC_SEQ_HALT_EN is defined.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_result;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] address;
  logic        if_flush, misalign_err, stall_timeout;
  logic [1:0]  state;
`ifdef PC_SEQ_HALT_EN
  logic        halt;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .Clk(clk), .Reset(reset), .PCResult(pc_result), .Stall(stall),
    .BranchTaken(branch_taken), .BranchTarget(branch_target),
    .Jump(jump), .JumpTarget(jump_target),
`ifdef PC_SEQ_HALT_EN
    .Halt(halt),
`endif
    .Address(address), .IF_Flush(if_flush), .MisalignErr(misalign_err),
    .StallTimeout(stall_timeout), .State(state)
  );

  always_ff @(posedge clk) pc_result <= address;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
`ifdef PC_SEQ_HALT_EN
    halt = 1'b0;
`endif
    tick(); tick();
    check("rst_addr", address, 32'h0);
    check("rst_flush", {31'b0, if_flush}, 32'd1);
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    check("rst_timeout", {31'b0, stall_timeout}, 32'd0);

    // free run
    reset = 1'b0; #1;
    check("init_state", {30'b0, state}, 32'd0);
    check("init_flush", {31'b0, if_flush}, 32'd1);
    check("init_addr", address, 32'h0);
    tick();
    check("run_pc0", pc_result, 32'h0);
    check("run_state", {30'b0, state}, 32'd1);
    check("run_flush0", {31'b0, if_flush}, 32'd0);
    check("run_addr4", address, 32'h4);
    tick(); check("run_pc4", pc_result, 32'h4);
    tick(); check("run_pc8", pc_result, 32'h8);

    // branch at 8
    branch_taken = 1'b1; branch_target = 32'h40; #1;
    check("br_flush", {31'b0, if_flush}, 32'd1);
    check("br_addr", address, 32'h40);
    check("br_misalign", {31'b0, misalign_err}, 32'd0);
    tick(); branch_taken = 1'b0;
    check("br_pc40", pc_result, 32'h40);
    tick(); check("br_pc44", pc_result, 32'h44);

    // jump outranks branch
    jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h40; #1;
    check("jb_addr", address, 32'h100);
    check("jb_flush", {31'b0, if_flush}, 32'd1);
    tick(); branch_taken = 1'b0; jump_target = 32'h0C;
    check("jb_pc100", pc_result, 32'h100);
    tick(); jump = 1'b0;
    check("jmp_pc0c", pc_result, 32'h0C);

    // 3-cycle stall with branch presented during the stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; #1;
    check("st_addr", address, 32'h0C);
    check("st_flush", {31'b0, if_flush}, 32'd0);
    tick();
    check("st_state", {30'b0, state}, 32'd2);
    check("st_pc_a", pc_result, 32'h0C);
    check("st_flush2", {31'b0, if_flush}, 32'd0);
    tick(); check("st_pc_b", pc_result, 32'h0C);
    tick(); check("st_pc_c", pc_result, 32'h0C);
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    check("st_exit_state", {30'b0, state}, 32'd1);
    check("st_exit_pc", pc_result, 32'h0C);
    check("st_exit_addr", address, 32'h10);
    check("st_no_timeout", {31'b0, stall_timeout}, 32'd0);
    tick(); check("st_pc10", pc_result, 32'h10);

    // timeout boundary: 15 cycles no flag, 16th sets it
    stall = 1'b1;
    repeat (15) tick();
    check("to_15", {31'b0, stall_timeout}, 32'd0);
    tick();
    check("to_16", {31'b0, stall_timeout}, 32'd1);
    check("to_pc_held", pc_result, 32'h10);
    stall = 1'b0;
    tick();
    check("to_sticky", {31'b0, stall_timeout}, 32'd1);
    check("to_run", {30'b0, state}, 32'd1);

    // misaligned redirects
    branch_taken = 1'b1; branch_target = 32'h43; #1;
    check("mis_pulse", {31'b0, misalign_err}, 32'd1);
    check("mis_addr", address, 32'h40);
    tick(); branch_taken = 1'b0; #1;
    check("mis_clear", {31'b0, misalign_err}, 32'd0);
    check("mis_pc40", pc_result, 32'h40);
    jump = 1'b1; jump_target = 32'h102; #1;
    check("mis_jmp_pulse", {31'b0, misalign_err}, 32'd1);
    check("mis_jmp_addr", address, 32'h100);
    tick(); jump = 1'b0;

    // reset in the middle of a stall
    stall = 1'b1;
    tick(); tick();
    reset = 1'b1; #1;
    check("rs_addr", address, 32'h0);
    check("rs_flush", {31'b0, if_flush}, 32'd1);
    tick();
    check("rs_state", {30'b0, state}, 32'd0);
    check("rs_pc", pc_result, 32'h0);
    check("rs_timeout", {31'b0, stall_timeout}, 32'd0);
    reset = 1'b0; stall = 1'b0;
    tick();
    check("rs_pc_run", pc_result, 32'h0);

    // wrap at top of address space
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); jump = 1'b0; #1;
    check("wr_pc", pc_result, 32'hFFFF_FFFC);
    check("wr_addr", address, 32'h0);
    check("wr_misalign", {31'b0, misalign_err}, 32'd0);
    tick(); check("wr_pc0", pc_result, 32'h0);
    tick(); check("wr_pc4", pc_result, 32'h4);

`ifdef PC_SEQ_HALT_EN
    halt = 1'b1;
    tick();
    check("h_state", {30'b0, state}, 32'd3);
    check("h_pc", pc_result, 32'h8);
    halt = 1'b0; jump = 1'b1; jump_target = 32'h200; stall = 1'b1; #1;
    check("h_addr", address, 32'h8);
    check("h_flush", {31'b0, if_flush}, 32'd0);
    tick(); tick();
    check("h_pc_frozen", pc_result, 32'h8);
    check("h_stays", {30'b0, state}, 32'd3);
    jump = 1'b0; stall = 1'b0;
`else
    tick();
    check("nh_state", {30'b0, state}, 32'd1);
    check("nh_pc", pc_result, 32'h8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter STALL_MAX, default 15, stall cycles before StallTimeout.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 PCResult  input  32  current PC from the ProgramCounter register.
REQ-006 Stall  input  1  hazard unit requests that the PC be held.
REQ-007 BranchTaken  input  1  branch resolved taken this cycle.
REQ-008 BranchTarget  input  32  branch destination.
REQ-009 Jump  input  1  jump (J/JAL/JR) resolved this cycle.
REQ-010 JumpTarget  input  32  jump destination.
REQ-011 Halt  input  1  halt request; exists only under PC_SEQ_HALT_EN.
REQ-012 Address  output  32  next-PC value driven to the ProgramCounter Address port.
REQ-013 IF_Flush  output  1  squash the instruction in IF/ID.
REQ-014 MisalignErr  output  1  one-cycle pulse on a redirect target with bits [1:0] != 0.
REQ-015 StallTimeout  output  1  sticky flag, stall held too long.
REQ-016 State  output  2  FSM state: 00 INIT, 01 RUN, 10 STALL, 11 HALT.

Function
REQ-017 FSM transitions: INIT->RUN unconditionally; RUN->STALL on Stall; STALL->RUN on !Stall; RUN/STALL->HALT on Halt; HALT is left only by Reset.
REQ-018 Address is combinational from State and the inputs; the ProgramCounter register adds the one cycle of latency, so the selection appears on PCResult after the next posedge.
REQ-019 In INIT, Address = RESET_VECTOR and IF_Flush = 1.
REQ-020 In RUN, Address is selected by priority: Stall -> PCResult; Jump -> JumpTarget; BranchTaken -> BranchTarget; otherwise PCResult + 4.
REQ-021 Stall outranks Jump and BranchTaken; a redirect presented while Stall = 1 is ignored and must be re-presented.
REQ-022 Jump outranks BranchTaken when both are asserted.
REQ-023 IF_Flush = 1 in the same cycle as any accepted redirect (Jump or BranchTaken, Stall = 0); IF_Flush = 0 otherwise outside INIT.
REQ-024 Redirect targets have bits [1:0] forced to 00 on Address; MisalignErr pulses for that cycle if the original bits were non-zero.
REQ-025 PC+4 uses 32-bit modulo arithmetic: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
REQ-026 In STALL, Address = PCResult; a 4-bit counter increments each STALL cycle, saturating at 15.
REQ-027 StallTimeout is set when the counter reaches STALL_MAX; it stays set until Reset.
REQ-028 The stall counter clears on entry to RUN.
REQ-029 In HALT, Address = PCResult, IF_Flush = 0, and all redirect and stall inputs are ignored.

Reset
REQ-030 Reset takes priority over every input, including mid-stall or mid-redirect.
REQ-031 On a Reset edge: State = INIT, stall counter = 0, StallTimeout = 0, MisalignErr = 0.
REQ-032 While Reset = 1: Address = RESET_VECTOR, IF_Flush = 1.
REQ-033 The first post-reset PCResult is RESET_VECTOR; PCResult + 4 follows one cycle later.

Configuration
REQ-034 PC_SEQ_HALT_EN defined: the Halt port and the HALT state exist, behaving per REQ-017 and REQ-029.
REQ-035 PC_SEQ_HALT_EN undefined: there is no Halt port, State never reads 11, and the remaining behaviour is unchanged.

Verification
REQ-036 Reset, then free run -> PCResult sequence 0, 4, 8, 12, 16; IF_Flush = 1 only during INIT.
REQ-037 At PCResult = 8, BranchTaken = 1 with BranchTarget = 0x40 -> IF_Flush = 1 that cycle; next PCResult = 0x40, then 0x44.
REQ-038 Jump = 1 (JumpTarget = 0x100) and BranchTaken = 1 (BranchTarget = 0x40) together -> PCResult = 0x100.
REQ-039 Stall for 3 cycles at PCResult = 0x0C, with BranchTaken asserted during the stall -> PCResult holds 0x0C, no flush, then 0x10; stall of 16 cycles -> StallTimeout = 1.
REQ-040 BranchTarget = 0x43 -> MisalignErr pulses for 1 cycle; PCResult = 0x40.
REQ-041 Reset asserted mid-stall, then PC at 0xFFFF_FFFC free run -> PCResult = 0 after reset; wrap 0xFFFF_FFFC -> 0x0 without error; with PC_SEQ_HALT_EN, Halt freezes PCResult.
